// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Constants shared by the Y86-64 pipeline stages: status
//               codes, instruction codes, register IDs and datapath sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 15;

  // Processor status codes
  localparam logic [3:0] c_STAT_AOK = 4'd1;
  localparam logic [3:0] c_STAT_HLT = 4'd2;
  localparam logic [3:0] c_STAT_ADR = 4'd3;
  localparam logic [3:0] c_STAT_INS = 4'd4;

  // Instruction codes
  localparam logic [3:0] c_ICODE_HALT   = 4'h0;
  localparam logic [3:0] c_ICODE_NOP    = 4'h1;
  localparam logic [3:0] c_ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] c_ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] c_ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] c_ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] c_ICODE_OPQ    = 4'h6;
  localparam logic [3:0] c_ICODE_JXX    = 4'h7;
  localparam logic [3:0] c_ICODE_CALL   = 4'h8;
  localparam logic [3:0] c_ICODE_RET    = 4'h9;
  localparam logic [3:0] c_ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] c_ICODE_POPQ   = 4'hB;

  // "No register" ID
  localparam logic [3:0] c_RNONE = 4'hF;

  // True when a status code lets the pipeline keep running
  function automatic logic is_aok(input logic [3:0] stat);
    return stat == c_STAT_AOK;
  endfunction

endpackage : y86_pkg
`default_nettype wire

// File: rtl/writeback_stage_regfile.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_regfile
// Description : Y86-64 architectural register file. Two asynchronous read
//               ports (ID >= NREG reads as zero), two synchronous write
//               ports where the M port wins on a shared destination.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage_regfile #(
  parameter int NREG = 15,
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_e_i,
  input  logic [3:0]      addr_e_i,
  input  logic [XLEN-1:0] data_e_i,
  input  logic            we_m_i,
  input  logic [3:0]      addr_m_i,
  input  logic [XLEN-1:0] data_m_i,
  input  logic [3:0]      rd_addr_a_i,
  output logic [XLEN-1:0] rd_data_a_o,
  input  logic [3:0]      rd_addr_b_i,
  output logic [XLEN-1:0] rd_data_b_o
);

  logic [XLEN-1:0] regs_q [NREG];

  // Register storage: clear on reset, M port has priority over E port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_m_i && (addr_m_i == 4'(i))) begin
          regs_q[i] <= data_m_i;
        end else if (we_e_i && (addr_e_i == 4'(i))) begin
          regs_q[i] <= data_e_i;
        end
      end
    end
  end

  // RNONE (and any ID beyond the file) reads as zero
  assign rd_data_a_o = (rd_addr_a_i < 4'(NREG)) ? regs_q[rd_addr_a_i] : '0;
  assign rd_data_b_o = (rd_addr_b_i < 4'(NREG)) ? regs_q[rd_addr_b_i] : '0;

endmodule : writeback_stage_regfile
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Y86-64 write-back stage. Holds the W pipeline register,
//               commits valE/valM into the register file, latches a sticky
//               halt on a non-AOK status and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int NREG = y86_pkg::NREG,
  parameter int XLEN = y86_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            W_stall,
  input  logic            W_bubble,
  input  logic [3:0]      M_stat,
  input  logic [3:0]      M_icode,
  input  logic [XLEN-1:0] M_valE,
  input  logic [XLEN-1:0] m_valM,
  input  logic [3:0]      M_dstE,
  input  logic [3:0]      M_dstM,
  input  logic            dmem_error,
  input  logic [3:0]      srcA,
  input  logic [3:0]      srcB,
  output logic [XLEN-1:0] rvalA,
  output logic [XLEN-1:0] rvalB,
  output logic [3:0]      W_stat,
  output logic [3:0]      W_icode,
  output logic [XLEN-1:0] W_valE,
  output logic [XLEN-1:0] W_valM,
  output logic [3:0]      W_dstE,
  output logic [3:0]      W_dstM,
  output logic [3:0]      stat,
  output logic            halted,
  output logic [63:0]     instr_count
);

  import y86_pkg::*;

  logic            valid_q;
  logic [3:0]      stat_q;
  logic [3:0]      icode_q;
  logic [XLEN-1:0] valE_q;
  logic [XLEN-1:0] valM_q;
  logic [3:0]      dstE_q;
  logic [3:0]      dstM_q;
  // Set once the instruction currently held in W has been retired, so a
  // stalled W register does not commit or count the same instruction twice.
  logic            retired_q;
  logic            halted_q;
  logic [63:0]     count_q;
  logic [63:0]     count_d;

  logic [3:0]      w_m_stat;
  logic            w_commit;
  logic            w_fault;

  assign w_m_stat = dmem_error ? c_STAT_ADR : M_stat;
  assign w_commit = valid_q && is_aok(stat_q) && !halted_q && !retired_q;
  assign w_fault  = valid_q && !is_aok(stat_q) && !halted_q;

  // W pipeline register: rst > halted > stall > bubble > load
  always_ff @(posedge clk) begin
    if (rst || (!halted_q && !W_stall && W_bubble)) begin
      valid_q   <= 1'b0;
      stat_q    <= c_STAT_AOK;
      icode_q   <= c_ICODE_NOP;
      valE_q    <= '0;
      valM_q    <= '0;
      dstE_q    <= c_RNONE;
      dstM_q    <= c_RNONE;
      retired_q <= 1'b0;
    end else if (halted_q) begin
      retired_q <= retired_q;
    end else if (W_stall) begin
      retired_q <= retired_q | w_commit;
    end else begin
      valid_q   <= 1'b1;
      stat_q    <= w_m_stat;
      icode_q   <= M_icode;
      valE_q    <= M_valE;
      valM_q    <= m_valM;
      dstE_q    <= M_dstE;
      dstM_q    <= M_dstM;
      retired_q <= 1'b0;
    end
  end

  // Next retired-instruction count, wrapping at 2^64
  always_comb begin
    count_d = count_q;
    if (w_commit) begin
      count_d = count_q + 64'd1;
    end
  end

  // Sticky halt latch and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (w_fault) begin
        halted_q <= 1'b1;
      end
      count_q <= count_d;
    end
  end

  writeback_stage_regfile #(
    .NREG (NREG),
    .XLEN (XLEN)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .we_e_i      (w_commit && (dstE_q != c_RNONE)),
    .addr_e_i    (dstE_q),
    .data_e_i    (valE_q),
    .we_m_i      (w_commit && (dstM_q != c_RNONE)),
    .addr_m_i    (dstM_q),
    .data_m_i    (valM_q),
    .rd_addr_a_i (srcA),
    .rd_data_a_o (rvalA),
    .rd_addr_b_i (srcB),
    .rd_data_b_o (rvalB)
  );

  assign W_stat      = stat_q;
  assign W_icode     = icode_q;
  assign W_valE      = valE_q;
  assign W_valM      = valM_q;
  assign W_dstE      = dstE_q;
  assign W_dstM      = dstM_q;
  assign stat        = valid_q ? stat_q : c_STAT_AOK;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Self-checking bench for writeback_stage. Expected W register
//               contents are queued when stimulus is driven and compared
//               after each capturing edge; RF, halt and counter are checked
//               inline against values tracked by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  import y86_pkg::*;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } wexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        W_stall = 1'b0;
  logic        W_bubble = 1'b0;
  logic [3:0]  M_stat = 4'd1;
  logic [3:0]  M_icode = 4'd1;
  logic [63:0] M_valE = '0;
  logic [63:0] m_valM = '0;
  logic [3:0]  M_dstE = 4'hF;
  logic [3:0]  M_dstM = 4'hF;
  logic        dmem_error = 1'b0;
  logic [3:0]  srcA = 4'hF;
  logic [3:0]  srcB = 4'hF;
  logic [63:0] rvalA, rvalB;
  logic [3:0]  W_stat, W_icode, W_dstE, W_dstM, stat;
  logic [63:0] W_valE, W_valM, instr_count;
  logic        halted;

  wexp_t sb_q[$];
  wexp_t got, exp;
  int    checks = 0;
  int    errors = 0;

  writeback_stage dut (
    .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
    .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .dmem_error(dmem_error),
    .srcA(srcA), .srcB(srcB), .rvalA(rvalA), .rvalB(rvalB),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .stat(stat), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic wexp_t bubble_w();
    return '{stat: 4'd1, icode: 4'd1, valE: 64'd0, valM: 64'd0, dstE: 4'hF, dstM: 4'hF};
  endfunction

  function automatic wexp_t mk_w(input logic [3:0] st, input logic [3:0] ic,
                                 input logic [63:0] ve, input logic [63:0] vm,
                                 input logic [3:0] de, input logic [3:0] dm);
    return '{stat: st, icode: ic, valE: ve, valM: vm, dstE: de, dstM: dm};
  endfunction

  function automatic wexp_t cur_w();
    return '{stat: W_stat, icode: W_icode, valE: W_valE, valM: W_valM, dstE: W_dstE, dstM: W_dstM};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [3:0] st, input logic [3:0] ic,
                            input logic [63:0] ve, input logic [63:0] vm,
                            input logic [3:0] de, input logic [3:0] dm,
                            input logic err);
    M_stat = st; M_icode = ic; M_valE = ve; m_valM = vm;
    M_dstE = de; M_dstM = dm; dmem_error = err;
    W_stall = 1'b0; W_bubble = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_load(4'd1, 4'd6, 64'hDEAD, 64'hBEEF, 4'd3, 4'd3, 1'b0);
    srcA = 4'd3;
    sb_q.push_back(bubble_w());
    tick(); tick();
    rst = 1'b0;
    W_bubble = 1'b1;
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_w got %h exp %h", got, exp); end
    checks++;
    if (stat !== 4'd1) begin errors++; $display("FAIL reset_stat got %0d exp 1", stat); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++;
    if (instr_count !== 64'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", instr_count); end
    checks++;
    if (rvalA !== 64'd0) begin errors++; $display("FAIL reset_reg3 got %h exp 0", rvalA); end
  endtask

  task automatic test_basic_commit();
    drive_load(4'd1, 4'd6, 64'h55, 64'h0, 4'd3, 4'hF, 1'b0);
    srcA = 4'd3;
    sb_q.push_back(mk_w(4'd1, 4'd6, 64'h55, 64'h0, 4'd3, 4'hF));
    tick();
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL basic_w got %h exp %h", got, exp); end
    checks++;
    if (rvalA !== 64'd0) begin errors++; $display("FAIL basic_old_read got %h exp 0", rvalA); end
    W_bubble = 1'b1;
    sb_q.push_back(bubble_w());
    tick();
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL basic_bubble_w got %h exp %h", got, exp); end
    checks++;
    if (rvalA !== 64'h55) begin errors++; $display("FAIL basic_new_read got %h exp 55", rvalA); end
    checks++;
    if (instr_count !== 64'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", instr_count); end
  endtask

  task automatic test_popq();
    drive_load(4'd1, 4'hB, 64'h100, 64'h200, 4'd4, 4'd4, 1'b0);
    sb_q.push_back(mk_w(4'd1, 4'hB, 64'h100, 64'h200, 4'd4, 4'd4));
    tick();
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL popq_w got %h exp %h", got, exp); end
    W_bubble = 1'b1;
    sb_q.push_back(bubble_w());
    tick();
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL popq_bubble_w got %h exp %h", got, exp); end
    srcA = 4'd4;
    #1;
    checks++;
    if (rvalA !== 64'h200) begin errors++; $display("FAIL popq_reg4 got %h exp 200", rvalA); end
    checks++;
    if (instr_count !== 64'd2) begin errors++; $display("FAIL popq_count got %0d exp 2", instr_count); end
  endtask

  task automatic test_stall();
    drive_load(4'd1, 4'd6, 64'h66, 64'h0, 4'd6, 4'hF, 1'b0);
    sb_q.push_back(mk_w(4'd1, 4'd6, 64'h66, 64'h0, 4'd6, 4'hF));
    tick();
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL stall_load_w got %h exp %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      drive_load(4'd1, 4'd3, 64'h1000 + 64'(i), 64'h2000 + 64'(i), 4'(i), 4'(i + 8), 1'b0);
      W_stall  = 1'b1;
      W_bubble = (i == 2);
      sb_q.push_back(mk_w(4'd1, 4'd6, 64'h66, 64'h0, 4'd6, 4'hF));
      tick();
      got = cur_w(); exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_hold_w%0d got %h exp %h", i, got, exp); end
    end
    checks++;
    if (instr_count !== 64'd3) begin errors++; $display("FAIL stall_count got %0d exp 3", instr_count); end
    srcA = 4'd6;
    #1;
    checks++;
    if (rvalA !== 64'h66) begin errors++; $display("FAIL stall_reg6 got %h exp 66", rvalA); end
    W_stall = 1'b0; W_bubble = 1'b1;
    sb_q.push_back(bubble_w());
    tick();
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL stall_release_w got %h exp %h", got, exp); end
    checks++;
    if (instr_count !== 64'd3) begin errors++; $display("FAIL stall_release_count got %0d exp 3", instr_count); end
  endtask

  task automatic test_bubble();
    drive_load(4'd1, 4'd6, 64'h77, 64'h0, 4'd7, 4'hF, 1'b0);
    W_bubble = 1'b1;
    sb_q.push_back(bubble_w());
    tick();
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bubble_w got %h exp %h", got, exp); end
    checks++;
    if (stat !== 4'd1) begin errors++; $display("FAIL bubble_stat got %0d exp 1", stat); end
    tick();
    srcA = 4'd7; srcB = 4'hF;
    #1;
    checks++;
    if (rvalA !== 64'd0) begin errors++; $display("FAIL bubble_reg7 got %h exp 0", rvalA); end
    checks++;
    if (rvalB !== 64'd0) begin errors++; $display("FAIL rnone_read got %h exp 0", rvalB); end
    checks++;
    if (instr_count !== 64'd3) begin errors++; $display("FAIL bubble_count got %0d exp 3", instr_count); end
  endtask

  task automatic test_error_halt();
    drive_load(4'd1, 4'hB, 64'h22, 64'h7, 4'd2, 4'd5, 1'b0);
    sb_q.push_back(mk_w(4'd1, 4'hB, 64'h22, 64'h7, 4'd2, 4'd5));
    tick();
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL pre_err_w got %h exp %h", got, exp); end
    drive_load(4'd1, 4'd6, 64'h99, 64'h0, 4'd2, 4'hF, 1'b1);
    sb_q.push_back(mk_w(4'd3, 4'd6, 64'h99, 64'h0, 4'd2, 4'hF));
    tick();
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL err_w got %h exp %h", got, exp); end
    checks++;
    if (stat !== 4'd3) begin errors++; $display("FAIL err_stat got %0d exp 3", stat); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL err_halt_early got %b exp 0", halted); end
    checks++;
    if (instr_count !== 64'd4) begin errors++; $display("FAIL err_pre_count got %0d exp 4", instr_count); end
    W_stall = 1'b1;
    sb_q.push_back(mk_w(4'd3, 4'd6, 64'h99, 64'h0, 4'd2, 4'hF));
    tick();
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL err_hold_w got %h exp %h", got, exp); end
    srcA = 4'd2; srcB = 4'd5;
    #1;
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL err_halted got %b exp 1", halted); end
    checks++;
    if (rvalA !== 64'h22) begin errors++; $display("FAIL err_reg2 got %h exp 22", rvalA); end
    drive_load(4'd1, 4'd6, 64'hAA, 64'h0, 4'd2, 4'hF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(mk_w(4'd3, 4'd6, 64'h99, 64'h0, 4'd2, 4'hF));
      tick();
      got = cur_w(); exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL halted_freeze_w%0d got %h exp %h", i, got, exp); end
    end
    checks++;
    if (instr_count !== 64'd4) begin errors++; $display("FAIL halted_count got %0d exp 4", instr_count); end
    checks++;
    if (rvalA !== 64'h22) begin errors++; $display("FAIL halted_reg2 got %h exp 22", rvalA); end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halted_sticky got %b exp 1", halted); end
  endtask

  task automatic test_reset_halted();
    srcB = 4'd5;
    #1;
    checks++;
    if (rvalB !== 64'h7) begin errors++; $display("FAIL pre_rst_reg5 got %h exp 7", rvalB); end
    rst = 1'b1;
    sb_q.push_back(bubble_w());
    tick();
    rst = 1'b0;
    W_bubble = 1'b1;
    got = cur_w(); exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_halt_w got %h exp %h", got, exp); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
    checks++;
    if (rvalB !== 64'd0) begin errors++; $display("FAIL rst_reg5 got %h exp 0", rvalB); end
    checks++;
    if (instr_count !== 64'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", instr_count); end
    checks++;
    if (W_icode !== 4'd1) begin errors++; $display("FAIL rst_icode got %0d exp 1", W_icode); end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_popq();
    test_stall();
    test_bubble();
    test_error_halt();
    test_reset_halted();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_writeback_stage
`default_nettype wire
